imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The core only reads this memory.
- Contains the 1024 x 32-bit instruction store.
- Accepts a byte stream from a host/testbench over a valid/ready handshake and packs the bytes big-endian into words, written sequentially from address 0.
- Serves the core's combinational fetch port (pc in, inst out) and holds the core in reset/stall while a load is in progress.

---
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory writer: packs a big-endian byte stream into 32-bit words,
// serves the core's combinational fetch port and holds the core while loading.
`timescale 1ns / 1ps

module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] OneW   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W:0]   r_target;
  logic [ADDR_W:0]   r_words_loaded;
  logic [ADDR_W:0]   w_target_new;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_shift;
  logic              w_xfer;
  logic              w_word_wr;
  logic              w_last;

  assign w_target_new = (load_words > DepthW) ? DepthW : load_words;

  // load_start takes priority over a coincident byte, which is dropped.
  assign w_xfer    = (r_state == StLoad) && byte_valid && !load_start;
  assign w_word_wr = w_xfer && (r_byte_cnt == 2'd3);
  assign w_last    = w_word_wr && ((r_words_loaded + OneW) == r_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    byte_ready   = 1'b0;
    cpu_hold     = 1'b0;
    load_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (load_start) w_state_next = (load_words == '0) ? StDone : StLoad;
      end
      StLoad: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (load_start) begin
          w_state_next = (load_words == '0) ? StDone : StLoad;
        end else if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        load_done = 1'b1;
        if (load_start) w_state_next = (load_words == '0) ? StDone : StLoad;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target       <= '0;
      r_words_loaded <= '0;
      r_wr_ptr       <= '0;
      r_byte_cnt     <= '0;
      r_shift        <= '0;
    end else if (load_start) begin
      r_target       <= w_target_new;
      r_words_loaded <= '0;
      r_wr_ptr       <= '0;
      r_byte_cnt     <= '0;
      r_shift        <= '0;
    end else if (w_xfer) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= {r_shift[15:0], byte_data};
      if (w_word_wr) begin
        // A full-depth load wraps the pointer back to 0 as it finishes.
        r_wr_ptr       <= r_wr_ptr + 1'b1;
        r_words_loaded <= r_words_loaded + OneW;
      end
    end
  end

  // Storage is deliberately not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (w_word_wr) r_mem[r_wr_ptr] <= {r_shift, byte_data};
  end

  assign inst         = r_mem[pc];
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected words are queued as bytes are driven
// and checked on the fetch port once each word completes.
`timescale 1ns / 1ps

module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_words = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic [ADDR_W-1:0] pc = '0;
  logic [31:0]       inst;
  logic              cpu_hold;
  logic              load_done;
  logic [ADDR_W:0]   words_loaded;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_words  (load_words),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .pc          (pc),
    .inst        (inst),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int n);
    load_start = 1'b1;
    load_words = (ADDR_W + 1)'(n);
    tick();
    load_start = 1'b0;
  endtask

  task automatic read_check(input string tag, input int a, input logic [31:0] exp);
    pc = ADDR_W'(a);
    #1;
    check(tag, inst, exp);
  endtask

  task automatic send_word(input int addr, input logic [31:0] word, input bit toggle,
                           input int exp_cnt);
    exp_t e;
    e.addr = ADDR_W'(addr);
    e.data = word;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (toggle) begin
        byte_valid = 1'b0;
        tick();
        check("hold_in_gap", 32'(cpu_hold), 32'd1);
      end
      byte_valid = 1'b1;
      byte_data  = word[31-8*k -: 8];
      check("ready_in_load", 32'(byte_ready), 32'd1);
      tick();
    end
    byte_valid = 1'b0;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      read_check("inst_after_word", int'(e.addr), e.data);
    end
    check("words_loaded", 32'(words_loaded), 32'(exp_cnt));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #12;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_count", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    tick();

    // Two-word load, valid held high
    start_load(2);
    check("t1_hold", 32'(cpu_hold), 32'd1);
    check("t1_done_low", 32'(load_done), 32'd0);
    send_word(0, 32'h8C010004, 1'b0, 1);
    send_word(1, 32'hAC020008, 1'b0, 2);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_hold_low", 32'(cpu_hold), 32'd0);
    check("t1_ready_low", 32'(byte_ready), 32'd0);
    read_check("t1_mem0", 0, 32'h8C010004);

    // Same load with valid toggling
    start_load(2);
    check("t2_done_clr", 32'(load_done), 32'd0);
    send_word(0, 32'h8C010004, 1'b1, 1);
    send_word(1, 32'hAC020008, 1'b1, 2);
    check("t2_done", 32'(load_done), 32'd1);
    read_check("t2_mem0", 0, 32'h8C010004);
    read_check("t2_mem1", 1, 32'hAC020008);

    // Abort after 6 bytes; the restart pulse coincides with a valid byte
    start_load(3);
    send_word(0, 32'hDEADBEEF, 1'b0, 1);
    byte_valid = 1'b1;
    byte_data  = 8'hCA;
    tick();
    byte_data  = 8'hFE;
    tick();
    byte_data  = 8'hEE;
    load_start = 1'b1;
    load_words = 11'd1;
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
    check("t3_count_clr", 32'(words_loaded), 32'd0);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    send_word(0, 32'h12345678, 1'b0, 1);
    check("t3_done", 32'(load_done), 32'd1);
    read_check("t3_mem1_kept", 1, 32'hAC020008);

    // Zero-length load
    start_load(0);
    check("t4_done", 32'(load_done), 32'd1);
    check("t4_hold", 32'(cpu_hold), 32'd0);
    check("t4_count", 32'(words_loaded), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    for (int k = 0; k < 4; k++) begin
      check("t4_ready", 32'(byte_ready), 32'd0);
      tick();
    end
    byte_valid = 1'b0;
    read_check("t4_mem0", 0, 32'h12345678);

    // Oversized load clamps to full depth
    start_load(1100);
    for (int i = 0; i < int'(DEPTH); i++) begin
      send_word(i, {16'(i), ~16'(i)}, 1'b0, i + 1);
    end
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_count", 32'(words_loaded), 32'(DEPTH));
    byte_valid = 1'b1;
    byte_data  = 8'h99;
    for (int k = 0; k < 4; k++) begin
      check("t5_ready_after", 32'(byte_ready), 32'd0);
      tick();
    end
    byte_valid = 1'b0;
    read_check("t5_mem1023", 1023, {16'd1023, ~16'd1023});
    read_check("t5_mem0", 0, 32'h0000FFFF);

    // Async reset mid-word
    start_load(2);
    byte_valid = 1'b1;
    byte_data  = 8'hAB;
    tick();
    byte_data  = 8'hCD;
    tick();
    byte_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_ready", 32'(byte_ready), 32'd0);
    check("t6_hold", 32'(cpu_hold), 32'd0);
    check("t6_done", 32'(load_done), 32'd0);
    check("t6_count", 32'(words_loaded), 32'd0);
    read_check("t6_mem5", 5, {16'd5, ~16'd5});
    #10;
    rst = 1'b0;
    tick();
    check("t6_idle_hold", 32'(cpu_hold), 32'd0);
    start_load(1);
    send_word(0, 32'h0BADF00D, 1'b0, 1);
    check("t6_done_after", 32'(load_done), 32'd1);
    read_check("t6_mem1", 1, {16'd1, ~16'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
